// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Feeds a pipelined Q6.9 MAC with operand pairs. Pairs are buffered in a small FIFO that
//   accepts data in every state (so a vector can be prefetched while idle). A start pulse
//   clears the MAC, streams exactly vec_len pairs into it, flushes the MAC pipeline with
//   zero operands, captures the accumulator and offers it on a valid/ready result port.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start, vec_len     begin a dot product of vec_len pairs (sampled only when idle)
//   busy               high whenever a dot product is in progress or its result is pending
//   in_valid/in_ready  operand pair handshake, in_a/in_b carry the pair
//   mac_clr            one-cycle clear pulse to the MAC
//   mac_en/mac_a/mac_b registered enable and operands to the MAC
//   mac_acc            MAC accumulator output
//   res_valid/res_ready/res_data  captured result handshake
//
// The drain length assumes MAC_LAT >= 2.

module mac_operand_sequencer #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DRN_W = (MAC_LAT > 2) ? $clog2(MAC_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DEPTH);
    // Drain counter runs 0 .. MAC_LAT-2, i.e. MAC_LAT-1 cycles.
    localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(MAC_LAT - 2);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StCapture,
        StResult
    } state_t;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [2*DATA_W-1:0] head;

    state_t state;
    state_t state_nxt;

    assign fifo_full  = (count == FIFO_FULL);
    assign fifo_empty = (count == '0);
    assign in_ready   = !fifo_full;
    // A full FIFO refuses the write even if a pop frees a slot in the same cycle.
    assign push       = in_valid && !fifo_full;
    assign pop        = (state == StStream) && !fifo_empty;
    assign head       = mem[rd_ptr];

    // Storage has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  len_nxt;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_nxt;
    logic [DRN_W-1:0]  drain_cnt;
    logic [DRN_W-1:0]  drain_nxt;
    logic              mac_en_nxt;
    logic [DATA_W-1:0] mac_a_nxt;
    logic [DATA_W-1:0] mac_b_nxt;
    logic              res_valid_nxt;
    logic [DATA_W-1:0] res_data_nxt;

    assign busy    = (state != StIdle);
    assign mac_clr = (state == StClear);

    always_comb begin
        state_nxt     = state;
        len_nxt       = len_r;
        cnt_nxt       = cnt;
        drain_nxt     = drain_cnt;
        mac_en_nxt    = 1'b0;
        mac_a_nxt     = mac_a;
        mac_b_nxt     = mac_b;
        res_valid_nxt = res_valid;
        res_data_nxt  = res_data;

        unique case (state)
            StIdle: begin
                if (start) begin
                    len_nxt   = vec_len;
                    cnt_nxt   = '0;
                    state_nxt = StClear;
                end
            end

            StClear: begin
                drain_nxt = '0;
                state_nxt = (len_r != '0) ? StStream : StDrain;
            end

            StStream: begin
                // An empty FIFO stalls the MAC: enable drops and operands hold.
                if (pop) begin
                    mac_en_nxt = 1'b1;
                    mac_a_nxt  = head[2*DATA_W-1:DATA_W];
                    mac_b_nxt  = head[DATA_W-1:0];
                    cnt_nxt    = cnt + 1'b1;
                    if (cnt == len_r - 1'b1) begin
                        drain_nxt = '0;
                        state_nxt = StDrain;
                    end
                end
            end

            StDrain: begin
                // Zero operands with enable high flush the last pair through the pipeline.
                mac_en_nxt = 1'b1;
                mac_a_nxt  = '0;
                mac_b_nxt  = '0;
                if (drain_cnt == DRN_LAST) begin
                    state_nxt = StCapture;
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end

            StCapture: begin
                res_data_nxt  = mac_acc;
                res_valid_nxt = 1'b1;
                state_nxt     = StResult;
            end

            StResult: begin
                if (res_valid && res_ready) begin
                    res_valid_nxt = 1'b0;
                    state_nxt     = StIdle;
                end
            end

            default: begin
                state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            len_r     <= '0;
            cnt       <= '0;
            drain_cnt <= '0;
            mac_en    <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_nxt;
            len_r     <= len_nxt;
            cnt       <= cnt_nxt;
            drain_cnt <= drain_nxt;
            mac_en    <= mac_en_nxt;
            mac_a     <= mac_a_nxt;
            mac_b     <= mac_b_nxt;
            res_valid <= res_valid_nxt;
            res_data  <= res_data_nxt;
        end
    end

endmodule
